// File: rtl/lsu_mem_port.sv
// LSU memory port: serializes one dequeued LSQ entry into per-lane data-memory
// accesses, gathers in-order load responses and retires with one masked RF write.
module lsu_mem_port #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LANES      = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_is_store,
   input  logic [1:0]                  req_warp_num,
   input  logic [3:0]                  req_dest_reg,
   input  logic [3:0]                  req_threads_mask,
   input  logic [LANES*ADDR_WIDTH-1:0] req_addr,
   input  logic [LANES*DATA_WIDTH-1:0] req_wdata,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic                        mem_rvalid,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
   output logic                        rf_write_en,
   output logic [LANES-1:0]            rf_lane_mask,
   output logic [3:0]                  rf_reg_addr,
   output logic [1:0]                  rf_warp_num,
   output logic [LANES*DATA_WIDTH-1:0] rf_write_data,
   output logic                        done_valid,
   output logic [1:0]                  done_warp_num
);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   function automatic logic [2:0] lowest_lane(input logic [LANES-1:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (m[i]) idx = i[2:0];
         else      idx = idx;
      end
      return idx;
   endfunction

   state_t                      state_r, state_nxt_s;
   logic                        is_store_r;
   logic [1:0]                  warp_r;
   logic [3:0]                  dest_r;
   logic [LANES-1:0]            lane_mask_r;
   logic [LANES*ADDR_WIDTH-1:0] addr_r;
   logic [LANES*DATA_WIDTH-1:0] wdata_r;
   logic [LANES*DATA_WIDTH-1:0] buf_r;
   logic [LANES-1:0]            issue_pend_r, resp_pend_r;
   logic [3:0]                  outstanding_r;

   logic [LANES-1:0]            req_lane_mask_s;
   logic [2:0]                  issue_ptr_s, resp_ptr_s;
   logic                        accept_s, issue_hs_s, issue_ld_s, resp_hs_s, rf_en_s;
   logic [LANES-1:0]            issue_pend_nxt_s, resp_pend_nxt_s;

   assign issue_ptr_s = lowest_lane(issue_pend_r);
   assign resp_ptr_s  = lowest_lane(resp_pend_r);
   assign accept_s    = (state_r == IDLE) && req_valid;
   assign issue_hs_s  = (state_r == ISSUE) && mem_req_ready;
   assign issue_ld_s  = issue_hs_s && !is_store_r;
   // Responses only count while a load request is actually in flight.
   assign resp_hs_s   = ((state_r == ISSUE) || (state_r == WAIT)) && !is_store_r
                        && mem_rvalid && (outstanding_r != 4'd0);
   assign rf_en_s     = (state_r == DONE) && !is_store_r && (lane_mask_r != {LANES{1'b0}});

   // Thread-mask expansion and pending-lane bookkeeping
   always_comb begin
      req_lane_mask_s = '0;
      for (int i = 0; i < LANES / 2; i++) begin
         req_lane_mask_s[2*i +: 2] = {2{req_threads_mask[i]}};
      end
      if (issue_hs_s) issue_pend_nxt_s = issue_pend_r & ~({{(LANES-1){1'b0}}, 1'b1} << issue_ptr_s);
      else            issue_pend_nxt_s = issue_pend_r;
      if (resp_hs_s)  resp_pend_nxt_s  = resp_pend_r & ~({{(LANES-1){1'b0}}, 1'b1} << resp_ptr_s);
      else            resp_pend_nxt_s  = resp_pend_r;
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = (req_lane_mask_s == {LANES{1'b0}}) ? DONE : ISSUE;
            else          state_nxt_s = IDLE;
         end
         ISSUE: begin
            if (issue_hs_s && (issue_pend_nxt_s == {LANES{1'b0}})) begin
               if (is_store_r || (resp_pend_nxt_s == {LANES{1'b0}})) state_nxt_s = DONE;
               else                                                  state_nxt_s = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            if (resp_pend_nxt_s == {LANES{1'b0}}) state_nxt_s = DONE;
            else                                  state_nxt_s = WAIT;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, latched entry, data buffer and outstanding-request counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         is_store_r    <= 1'b0;
         warp_r        <= 2'd0;
         dest_r        <= 4'd0;
         lane_mask_r   <= '0;
         addr_r        <= '0;
         wdata_r       <= '0;
         buf_r         <= '0;
         issue_pend_r  <= '0;
         resp_pend_r   <= '0;
         outstanding_r <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            is_store_r    <= req_is_store;
            warp_r        <= req_warp_num;
            dest_r        <= req_dest_reg;
            lane_mask_r   <= req_lane_mask_s;
            addr_r        <= req_addr;
            wdata_r       <= req_wdata;
            buf_r         <= '0;
            issue_pend_r  <= req_lane_mask_s;
            resp_pend_r   <= req_is_store ? {LANES{1'b0}} : req_lane_mask_s;
            outstanding_r <= 4'd0;
         end else begin
            issue_pend_r  <= issue_pend_nxt_s;
            resp_pend_r   <= resp_pend_nxt_s;
            outstanding_r <= outstanding_r + {3'd0, issue_ld_s} - {3'd0, resp_hs_s};
            if (resp_hs_s) buf_r[resp_ptr_s*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
            else           buf_r <= buf_r;
         end
      end
   end

   // Output decode; everything idles at 0 outside its owning state
   always_comb begin
      req_ready     = (state_r == IDLE) && reset;
      mem_req_valid = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      rf_write_en   = 1'b0;
      rf_lane_mask  = '0;
      rf_reg_addr   = 4'd0;
      rf_warp_num   = 2'd0;
      rf_write_data = '0;
      done_valid    = 1'b0;
      done_warp_num = 2'd0;
      if (state_r == ISSUE) begin
         mem_req_valid = 1'b1;
         mem_we        = is_store_r;
         mem_addr      = addr_r[issue_ptr_s*ADDR_WIDTH +: ADDR_WIDTH];
         mem_wdata     = wdata_r[issue_ptr_s*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         mem_req_valid = 1'b0;
      end
      if (state_r == DONE) begin
         done_valid    = 1'b1;
         done_warp_num = warp_r;
      end else begin
         done_valid    = 1'b0;
      end
      if (rf_en_s) begin
         rf_write_en   = 1'b1;
         rf_lane_mask  = lane_mask_r;
         rf_reg_addr   = dest_r;
         rf_warp_num   = warp_r;
         rf_write_data = buf_r;
      end else begin
         rf_write_en   = 1'b0;
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: stimulus queues expected memory requests and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_mem_port;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int L  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_ready, req_is_store = 1'b0;
   logic [1:0]    req_warp_num = 2'd0;
   logic [3:0]    req_dest_reg = 4'd0, req_threads_mask = 4'd0;
   logic [L*AW-1:0] req_addr = '0;
   logic [L*DW-1:0] req_wdata = '0;
   logic          mem_req_valid, mem_req_ready = 1'b1, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          rf_write_en;
   logic [L-1:0]  rf_lane_mask;
   logic [3:0]    rf_reg_addr;
   logic [1:0]    rf_warp_num;
   logic [L*DW-1:0] rf_write_data;
   logic          done_valid;
   logic [1:0]    done_warp_num;

   lsu_mem_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_warp_num(req_warp_num), .req_dest_reg(req_dest_reg),
      .req_threads_mask(req_threads_mask), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .rf_write_en(rf_write_en), .rf_lane_mask(rf_lane_mask),
      .rf_reg_addr(rf_reg_addr), .rf_warp_num(rf_warp_num), .rf_write_data(rf_write_data),
      .done_valid(done_valid), .done_warp_num(done_warp_num)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [7:0] addr; logic [15:0] wdata; } mem_exp_t;
   typedef struct { logic [1:0] warp; logic en; logic [7:0] mask; logic [3:0] rg;
                    logic [127:0] data; int cyc; } done_exp_t;

   mem_exp_t  mq[$];
   done_exp_t dq[$];
   logic [15:0] mem [256];
   int cyc = 0;
   int nvec = 0;
   int nfail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Memory responder: read data returns two cycles after the request handshake
   logic d1_v = 1'b0, d2_v = 1'b0;
   logic [15:0] d1_d = '0, d2_d = '0;
   always @(negedge clk) begin
      mem_rvalid = d2_v;
      mem_rdata  = d2_d;
      d2_v = d1_v;
      d2_d = d1_d;
      d1_v = mem_req_valid && mem_req_ready && !mem_we;
      d1_d = mem[mem_addr];
   end

   // Monitor: pops the scoreboard on every memory handshake and completion
   mem_exp_t  me;
   done_exp_t de;
   always @(negedge clk) begin
      if (mem_req_valid && mem_req_ready) begin
         if (mq.size() == 0) chk("mem_unexpected", 1'b1, 1'b0);
         else begin
            me = mq.pop_front();
            chk("mem_we", mem_we, me.we);
            chk("mem_addr", mem_addr, me.addr);
            if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
         end
      end else if (mem_req_valid) begin
         if (mq.size() == 0) chk("mem_unexpected_stall", 1'b1, 1'b0);
         else                chk("mem_hold_addr", mem_addr, mq[0].addr);
      end
      if (done_valid) begin
         if (dq.size() == 0) chk("done_unexpected", 1'b1, 1'b0);
         else begin
            de = dq.pop_front();
            chk("done_cycle", cyc, de.cyc);
            chk("done_warp", done_warp_num, de.warp);
            chk("rf_write_en", rf_write_en, de.en);
            if (de.en) begin
               chk("rf_lane_mask", rf_lane_mask, de.mask);
               chk("rf_reg_addr", rf_reg_addr, de.rg);
               chk("rf_warp_num", rf_warp_num, de.warp);
               chk("rf_write_data", rf_write_data, de.data);
            end
         end
      end else if (rf_write_en) begin
         chk("rf_without_done", 1'b1, 1'b0);
      end
   end

   task automatic pm(input logic we, input logic [7:0] a, input logic [15:0] wd);
      mem_exp_t e;
      e.we = we; e.addr = a; e.wdata = wd;
      mq.push_back(e);
   endtask

   task automatic send(input logic st, input logic [1:0] w, input logic [3:0] rg,
                       input logic [3:0] m, input logic [63:0] ad, input logic [127:0] wd,
                       input logic en, input logic [7:0] xmask, input logic [127:0] xdata,
                       input int lat, input logic hold, output int acc);
      done_exp_t d;
      req_is_store = st; req_warp_num = w; req_dest_reg = rg;
      req_threads_mask = m; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 50 && acc < 0; k++) begin
         @(negedge clk);
         if (req_ready) acc = cyc;
      end
      if (acc < 0) chk("accept_timeout", 1'b0, 1'b1);
      else begin
         d.warp = w; d.en = en; d.mask = xmask; d.rg = rg; d.data = xdata; d.cyc = acc + lat;
         dq.push_back(d);
      end
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (dq.size() != 0 || mq.size() != 0); k++) @(negedge clk);
      chk("drain_done_q", dq.size(), 0);
      chk("drain_mem_q", mq.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc2;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'hAAAA; mem[8'h11] = 16'hBBBB;
      for (int i = 0; i < 8; i++) mem[8'h20 + i] = 16'h1111 * 16'(i + 1);
      mem[8'h40] = 16'hDEAD; mem[8'h41] = 16'hBEEF; mem[8'h42] = 16'hCAFE; mem[8'h43] = 16'hF00D;
      mem[8'hFF] = 16'h5555; mem[8'h70] = 16'h7070; mem[8'h71] = 16'h7171;

      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", req_ready, 1'b0);
      chk("reset_mem_req_valid", mem_req_valid, 1'b0);
      chk("reset_done_valid", done_valid, 1'b0);
      reset = 1'b1;
      #1 chk("post_reset_req_ready", req_ready, 1'b1);
      @(posedge clk); #1;

      // Load, lanes 0/1
      pm(1'b0, 8'h10, 16'h0); pm(1'b0, 8'h11, 16'h0);
      send(1'b0, 2'd1, 4'd5, 4'b0001, {48'h0, 8'h11, 8'h10}, '0, 1'b1, 8'h03,
           {96'h0, 16'hBBBB, 16'hAAAA}, 5, 1'b0, acc);
      drain();

      // Store, lanes 6/7
      pm(1'b1, 8'h56, 16'h1234); pm(1'b1, 8'h57, 16'h5678);
      send(1'b1, 2'd2, 4'd0, 4'b1000, {8'h57, 8'h56, 48'h0}, {16'h5678, 16'h1234, 96'h0},
           1'b0, 8'h00, '0, 3, 1'b0, acc);
      drain();

      // Empty mask load
      send(1'b0, 2'd3, 4'd2, 4'b0000, {8{8'h10}}, '0, 1'b0, 8'h00, '0, 1, 1'b0, acc);
      @(negedge clk); chk("mask0_ready_in_done", req_ready, 1'b0);
      @(negedge clk); chk("mask0_ready_after", req_ready, 1'b1);
      drain();

      // Full-mask load with three stall cycles on lane 2
      for (int i = 0; i < 8; i++) pm(1'b0, 8'(8'h20 + i), 16'h0);
      send(1'b0, 2'd3, 4'hA, 4'b1111,
           {8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20}, '0, 1'b1, 8'hFF,
           {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
           14, 1'b0, acc);
      @(posedge clk); #1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 mem_req_ready = 1'b1;
      drain();

      // Reset with two loads outstanding: entry abandoned, strays ignored
      pm(1'b0, 8'h30, 16'h0); pm(1'b0, 8'h31, 16'h0); pm(1'b0, 8'h32, 16'h0);
      req_is_store = 1'b0; req_warp_num = 2'd0; req_dest_reg = 4'd3; req_threads_mask = 4'b1111;
      req_addr = {8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h30}; req_valid = 1'b1;
      @(negedge clk); chk("abort_accept_ready", req_ready, 1'b1);
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_mem_req_valid", mem_req_valid, 1'b0);
      chk("abort_req_ready", req_ready, 1'b0);
      chk("abort_done_valid", done_valid, 1'b0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("abort_idle_ready", req_ready, 1'b1);
      drain();

      // Load after abort, lanes 2..5; unused lanes point at a poisoned address
      pm(1'b0, 8'h40, 16'h0); pm(1'b0, 8'h41, 16'h0); pm(1'b0, 8'h42, 16'h0); pm(1'b0, 8'h43, 16'h0);
      send(1'b0, 2'd1, 4'd7, 4'b0110,
           {8'hFF, 8'hFF, 8'h43, 8'h42, 8'h41, 8'h40, 8'hFF, 8'hFF}, '0, 1'b1, 8'h3C,
           {32'h0, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD, 32'h0}, 7, 1'b0, acc);
      drain();

      // Back-to-back entries with req_valid held high
      pm(1'b1, 8'h60, 16'h0A0A); pm(1'b1, 8'h61, 16'h0B0B);
      pm(1'b0, 8'h70, 16'h0); pm(1'b0, 8'h71, 16'h0);
      send(1'b1, 2'd2, 4'd1, 4'b0001, {48'h0, 8'h61, 8'h60}, {96'h0, 16'h0B0B, 16'h0A0A},
           1'b0, 8'h00, '0, 3, 1'b1, acc);
      send(1'b0, 2'd3, 4'd9, 4'b0010, {32'h0, 8'h71, 8'h70, 16'h0}, '0, 1'b1, 8'h0C,
           {64'h0, 16'h7171, 16'h7070, 32'h0}, 5, 1'b0, acc2);
      chk("b2b_second_accept_cycle", acc2 - acc, 4);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Downstream stage of the load-store unit. It takes one dequeued LSQ entry at a time: a warp's load or store, with eight per-lane addresses and a thread mask. It serializes the entry into per-lane accesses on the single-ported data memory and collects in-order load responses. On completion it performs one masked write into the threads register file and pulses done to the scoreboard.

Parameters:
DATA_WIDTH, 16, lane data width
ADDR_WIDTH, 8, data memory address width
LANES, 8, lanes per warp; fixed at 8 in this revision

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  1  LSQ entry available
req_ready  out  1  block accepts entry
req_is_store  in  1  1 = store, 0 = load
req_warp_num  in  2  warp of entry
req_dest_reg  in  4  destination register (loads)
req_threads_mask  in  4  bit i enables lanes 2i and 2i+1
req_addr  in  8 x ADDR_WIDTH  per-lane address
req_wdata  in  8 x DATA_WIDTH  per-lane store data
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  request address
mem_wdata  out  DATA_WIDTH  write data
mem_rvalid  in  1  read response valid; responses return in request order
mem_rdata  in  DATA_WIDTH  read response data
rf_write_en  out  1  register file write strobe
rf_lane_mask  out  8  lanes written
rf_reg_addr  out  4  register written
rf_warp_num  out  2  warp written
rf_write_data  out  8 x DATA_WIDTH  per-lane write data
done_valid  out  1  one-cycle completion pulse to scoreboard
done_warp_num  out  2  warp completed

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset → IDLE.
- Reset values: all registers and outputs 0. req_ready is 1 in IDLE only, so it reads 1 immediately after reset deasserts.
- Async reset mid-operation abandons the entry. No done, no rf write. mem_rvalid arriving afterwards in IDLE is ignored.
- IDLE: on req_valid && req_ready, latch all req_* fields. Expand mask to lane_mask[2i+1:2i] = {2{mask[i]}}.
  - lane_mask==0 → DONE.
  - Otherwise → ISSUE with issue pointer at the lowest enabled lane.
- ISSUE:
  - mem_req_valid=1; mem_addr/mem_wdata come from the current lane; mem_we = is_store.
  - Outputs hold stable while mem_req_ready=0.
  - On handshake, advance to the next higher enabled lane.
  - After the last enabled lane's handshake: store → DONE; load → WAIT, unless all responses are already in, in which case → DONE.
- Load responses, accepted in ISSUE or WAIT:
  - Each mem_rvalid writes mem_rdata into the data buffer at the response pointer (lowest enabled lane not yet returned). The response pointer then advances.
  - mem_rvalid with zero outstanding requests is ignored.
  - A response and a new issue in the same cycle are both handled.
- WAIT: mem_req_valid=0. The edge that captures the last response moves to DONE.
- DONE (exactly one cycle, req_ready=0):
  - done_valid=1, done_warp_num = latched warp.
  - If load with nonzero mask: rf_write_en=1, rf_lane_mask=lane_mask, rf_reg_addr/rf_warp_num latched, rf_write_data = buffer. Disabled lanes drive 0.
  - Stores and empty masks keep rf_write_en=0.
  - Next state IDLE. The earliest next acceptance is the cycle after DONE.
- Stores complete on memory handshake; no response is expected.
- Data buffer is cleared to 0 on each acceptance.
- Outstanding counter is 4 bits; it never exceeds 8.

Test Plan:
- Load, mask 4'b0001, lanes 0/1 at addr 8'h10/8'h11, memory always ready, latency 2, data 16'hAAAA/16'hBBBB → accept cycle 0; issues cycles 1–2; rvalid cycles 3–4; cycle 5 has done_valid=1, rf_write_en=1, rf_lane_mask=8'h03, lanes 0/1 = AAAA/BBBB, others 0.
- Store, mask 4'b1000, lanes 6/7 data 16'h1234/16'h5678 → two write requests: addr lane6 then lane7, mem_we=1. DONE in cycle 3 with rf_write_en=0.
- Mask 4'b0000 load → no mem_req_valid; done_valid in cycle 1; rf_write_en=0; req_ready returns to 1 in cycle 2.
- Backpressure: mem_req_ready low 3 cycles during lane 2 of a full-mask load → mem_addr held stable. All 8 lanes return in order. rf_lane_mask=8'hFF; data lands in the correct lanes.
- Reset asserted while 2 responses are outstanding → outputs 0 asynchronously. A later stray mem_rvalid is ignored. The next load completes correctly and no done is seen for the aborted entry.
- Back-to-back: req_valid held high with two entries → req_ready=0 from acceptance through DONE. The second entry is accepted the cycle after the first done_valid, with the correct warp_num on each done.
